rr_pkt_mux: RTL and testbench
=============================

// Module: rr_pkt_mux
// PURPOSE
//  Packet-level N:1 stream mux downstream of rnd_robin_arbiter (REG_OUTPUT=1).
//  - Presents port valids to the arbiter as requests and pulses its enable.
//  - Consumes the registered grant and locks the selected port until the beat with last=1.
//  - Forwards beats through one registered output stage with valid/ready handshake.
// PARAMETERS
//  PORTS   8   number of input streams; must equal arbiter PORTS, >=2
//  DWIDTH  32  data width per beat
// PORTS
//  clk             in   1              clock
//  rst             in   1              synchronous reset, active-high
//  in_valid        in   PORTS          per-port beat valid
//  in_data         in   PORTS*DWIDTH   port p data at [p*DWIDTH +: DWIDTH]
//  in_last         in   PORTS          per-port end-of-packet flag
//  in_ready        out  PORTS          per-port beat accept
//  arb_request     out  PORTS          to arbiter request
//  arb_enable      out  1              to arbiter enable, one-cycle pulse
//  arb_grant       in   PORTS          from arbiter grant (one-hot, registered)
//  arb_grant_port  in   $clog2(PORTS)  from arbiter grant_port
//  arb_grant_dv    in   1              from arbiter grant_port_dv
//  out_valid       out  1              output beat valid
//  out_data        out  DWIDTH         output beat data
//  out_last        out  1              output end-of-packet
//  out_ready       in   1              downstream accept
//  busy            out  1              packet in progress (state != IDLE)
// BEHAVIOUR
//  Reset, sync active-high:
//  - state=IDLE, sel=0, out_valid=0, out_data=0, out_last=0, arb_enable=0, busy=0.
//  - A reset mid-packet drops the packet; the downstream sees no further beats.
//  arb_request = in_valid, combinational and in every state.
//  Beats are accepted on in_valid[p] & in_ready[p]; out_valid & out_ready retires a beat.
//  FSM:
//  - IDLE: if |in_valid: arb_enable=1 this cycle -> GNT. Else stay in IDLE.
//  - GNT: the arbiter grant is valid this cycle, one cycle after enable.
//    - If arb_grant_dv & |arb_grant: sel<=arb_grant_port -> XFER.
//    - If arb_grant==0 (request withdrawn): -> IDLE.
//    - Otherwise (dv low): wait in GNT.
//  - XFER: accepting a beat on port sel with in_last[sel]=1 -> IDLE. Otherwise stay.
//    - No re-arbitration while in XFER.
//    - Gaps (in_valid[sel]=0) are legal and the lock is held.
//  in_ready:
//  - in_ready[sel] = (state==XFER) & (~out_valid | out_ready).
//  - All other in_ready bits are 0. All in_ready bits are 0 outside XFER.
//  Output register:
//  - Loads in_data[sel] and in_last[sel] on an accepted beat; out_valid<=1.
//  - Otherwise, if out_ready, out_valid<=0.
//  - Data and last are held stable while out_valid & ~out_ready.
//  Throughput and latency:
//  - Latency is 1 cycle from input accept to out_valid.
//  - One beat per cycle while out_ready=1.
//  - Arbitration overhead is 2 cycles per packet (IDLE+GNT).
//  Boundary cases:
//  - Single-beat packet (last on first beat): accept, then IDLE next cycle.
//  - out_ready low on the last beat: the beat is held in the output register.
//    The FSM still returns to IDLE, and a new packet cannot overwrite the held beat.
//  - Only one port requesting: it wins every arbitration; there is no starvation of others.
//  - in_last on a non-selected port is ignored.
//  - in_valid asserted in the same cycle as rst: ignored.
//  - Arbiter grant rotates per enable, so fairness is per packet, not per beat.
// TESTING
//  - Reset, then in_valid=0 for 5 cycles -> arb_enable=0, all in_ready=0, out_valid=0.
//  - Port2 sends 3-beat pkt (0xA0,0xA1,0xA2, last on 3rd), out_ready=1
//    -> arb_enable pulse in cycle 0, first in_ready in cycle 2.
//    -> out_data=0xA0..0xA2 on consecutive cycles; out_last only with 0xA2.
//  - Ports 0,1,3 each hold a 2-beat pkt at once
//    -> packets emerge whole, never interleaved, order 0,1,3 from reset priority.
//  - out_ready toggles 1,0,0,1 mid-packet -> out_data stable while stalled.
//    -> in_ready[sel]=0 during stall, no beat lost or duplicated.
//  - Port5 single-beat pkts back-to-back, port6 idle
//    -> each pkt takes 3 cycles (enable, grant, transfer), busy low between pkts.
//  - rst asserted in XFER after beat 1 of 4 -> next cycle state=IDLE, out_valid=0.
//    -> a subsequent request re-arbitrates cleanly.

Source files
------------

// File: rtl/rr_pkt_mux.sv
// rr_pkt_mux: packet-level N:1 stream mux sitting behind a round-robin arbiter
// with a registered grant. Port valids go straight to the arbiter as requests.
// One enable pulse is issued per packet. The granted port stays locked until
// its last beat is accepted. Beats pass through a single registered output
// stage with a valid/ready handshake.
module rr_pkt_mux #(
    parameter int PORTS  = 8,
    parameter int DWIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS-1:0]           in_valid,
    input  logic [PORTS*DWIDTH-1:0]    in_data,
    input  logic [PORTS-1:0]           in_last,
    output logic [PORTS-1:0]           in_ready,
    output logic [PORTS-1:0]           arb_request,
    output logic                       arb_enable,
    input  logic [PORTS-1:0]           arb_grant,
    input  logic [$clog2(PORTS)-1:0]   arb_grant_port,
    input  logic                       arb_grant_dv,
    output logic                       out_valid,
    output logic [DWIDTH-1:0]          out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int SW = $clog2(PORTS);

    typedef enum logic [1:0] {
        IDLE,
        GNT,
        XFER
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic                out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic                sel_valid;
    logic                sel_last;
    logic [DWIDTH-1:0]   sel_data;
    logic                out_free;
    logic                xfer;
    logic                accept;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = ~out_valid_q | out_ready;
    assign xfer     = (state_q == XFER);
    assign accept   = xfer & out_free & sel_valid;

    assign arb_request = in_valid;
    assign busy        = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;

    // Select the locked port's valid, last and data.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (SW'(p) == sel_q) begin
                sel_valid = in_valid[p];
                sel_last  = in_last[p];
                sel_data  = in_data[p*DWIDTH +: DWIDTH];
            end
        end
    end

    // Only the locked port sees ready, and only while in XFER with output room.
    always_comb begin
        in_ready = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            in_ready[p] = xfer & out_free & (SW'(p) == sel_q);
        end
    end

    // Packet FSM: arbitrate in IDLE, capture the grant in GNT, then hold the lock
    // in XFER until the last beat.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        arb_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Requests seen while reset is high must not start an arbitration.
                if ((|in_valid) && !rst) begin
                    arb_enable = 1'b1;
                    state_d    = GNT;
                end
            end
            GNT: begin
                if (arb_grant_dv && (|arb_grant)) begin
                    sel_d   = arb_grant_port;
                    state_d = XFER;
                end else if (arb_grant == '0) begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage next state: load on accept, drop valid once retired.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, lock and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_rr_pkt_mux.sv
// Testbench for rr_pkt_mux: cycle table for reset and a single packet, then
// source/scoreboard sequences for arbitration order, stalls, back-to-back
// single-beat packets, held last beat and reset mid-packet.
module tb_rr_pkt_mux;

    localparam int PORTS  = 8;
    localparam int DWIDTH = 32;
    localparam int SW     = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [PORTS-1:0]         in_valid;
    logic [PORTS*DWIDTH-1:0]  in_data;
    logic [PORTS-1:0]         in_last;
    logic [PORTS-1:0]         in_ready;
    logic [PORTS-1:0]         arb_request;
    logic                     arb_enable;
    logic [PORTS-1:0]         arb_grant;
    logic [SW-1:0]            arb_grant_port;
    logic                     arb_grant_dv;
    logic                     out_valid;
    logic [DWIDTH-1:0]        out_data;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_pkt_mux #(.PORTS(PORTS), .DWIDTH(DWIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .arb_request    (arb_request),
        .arb_enable     (arb_enable),
        .arb_grant      (arb_grant),
        .arb_grant_port (arb_grant_port),
        .arb_grant_dv   (arb_grant_dv),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    // Round-robin arbiter model with registered grant, valid the cycle after enable.
    int arb_ptr;
    always @(posedge clk) begin : arb_model
        bit found;
        int idx;
        if (rst) begin
            arb_grant      <= '0;
            arb_grant_port <= '0;
            arb_grant_dv   <= 1'b0;
            arb_ptr        <= 0;
        end else if (arb_enable) begin
            found = 1'b0;
            for (int k = 0; k < PORTS; k++) begin
                idx = (arb_ptr + k) % PORTS;
                if (!found && arb_request[idx]) begin
                    found = 1'b1;
                    arb_grant      <= PORTS'(1) << idx;
                    arb_grant_port <= SW'(idx);
                    arb_ptr        <= (idx + 1) % PORTS;
                end
            end
            if (!found) arb_grant <= '0;
            arb_grant_dv <= found;
        end else begin
            arb_grant    <= '0;
            arb_grant_dv <= 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        rst;
        logic [7:0]  v;
        logic [7:0]  l;
        logic [31:0] d;
        logic        ordy;
        logic        en;
        logic [7:0]  rdy;
        logic        busy;
        logic        ov;
        logic [31:0] od;
        logic        ol;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic [7:0] v, input logic [7:0] l,
                                input logic [31:0] d, input logic ordy, input logic en,
                                input logic [7:0] rdy, input logic bsy, input logic ov,
                                input logic [31:0] od, input logic ol);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.d = d; t.ordy = ordy;
        t.en = en; t.rdy = rdy; t.busy = bsy; t.ov = ov; t.od = od; t.ol = ol;
        return t;
    endfunction

    // ---------------- sources and scoreboard ----------------
    logic [32:0] src_mem [PORTS][32];
    int          src_head [PORTS];
    int          src_tail [PORTS];
    logic [32:0] exp_q [$];
    bit          ordy_q [$];
    int          acc_cyc_q [$];
    int          cyc   = 0;
    int          n_acc = 0;
    logic        prev_ov, prev_ordy, prev_ol, prev_rst, prev_last_acc;
    logic [31:0] prev_od;

    task automatic push_beat(input int p, input logic [23:0] d, input logic last, input bit to_exp);
        logic [32:0] b;
        b = {last, 8'(p), d};
        src_mem[p][src_tail[p]] = b;
        src_tail[p]++;
        if (to_exp) exp_q.push_back(b);
    endtask

    function automatic bit pending();
        bit r = 1'b0;
        for (int p = 0; p < PORTS; p++) if (src_head[p] != src_tail[p]) r = 1'b1;
        return r;
    endfunction

    task automatic drive_inputs();
        logic [32:0] b;
        for (int p = 0; p < PORTS; p++) begin
            if (src_head[p] != src_tail[p]) begin
                b = src_mem[p][src_head[p]];
                in_valid[p] = 1'b1;
                in_last[p]  = b[32];
                in_data[p*DWIDTH +: DWIDTH] = b[31:0];
            end else begin
                in_valid[p] = 1'b0;
                in_last[p]  = 1'b0;
                in_data[p*DWIDTH +: DWIDTH] = {8'(p), 24'hEEEEEE};
            end
        end
    endtask

    task automatic next_ordy();
        if (ordy_q.size() != 0) out_ready = ordy_q.pop_front();
        else out_ready = 1'b1;
    endtask

    task automatic step();
        logic [PORTS-1:0] acc;
        logic [32:0]      e;
        @(negedge clk);
        chk("arb_request", arb_request, in_valid);
        acc = in_valid & in_ready;
        if (prev_ov && !prev_ordy && !prev_rst)
            chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_ol, prev_od});
        if (out_valid && !out_ready)
            chk("stall_in_ready", in_ready, '0);
        if (prev_last_acc && !prev_rst)
            chk("idle_after_last", busy, 1'b0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat actual=0x%0h required=none", {out_last, out_data});
            end else begin
                e = exp_q.pop_front();
                chk("beat", {out_last, out_data}, e);
            end
        end
        prev_ov = out_valid; prev_ordy = out_ready; prev_od = out_data;
        prev_ol = out_last;  prev_rst = rst;
        prev_last_acc = |(acc & in_last);
        for (int p = 0; p < PORTS; p++) begin
            if (acc[p]) begin
                acc_cyc_q.push_back(cyc);
                n_acc++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int p = 0; p < PORTS; p++) if (acc[p] && src_head[p] != src_tail[p]) src_head[p]++;
        drive_inputs();
        next_ordy();
    endtask

    task automatic run_until_idle(input string name, input int max);
        int n = 0;
        while ((pending() || exp_q.size() != 0 || out_valid) && n < max) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= max) begin
            n_fail++;
            $display("FAIL %s_timeout actual=%0d_cycles required=<%0d left=%0d", name, n, max, exp_q.size());
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        for (int p = 0; p < PORTS; p++) begin
            src_head[p] = 0;
            src_tail[p] = 0;
        end
        exp_q.delete();
        ordy_q.delete();
        drive_inputs();
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        drive_inputs();
    endtask

    initial begin
        int base;
        bit got;

        tbl[0]  = mk(1, 8'hFF, 8'h00, 32'h00, 1, 0, 8'h00, 0, 0, 32'h0, 0);
        for (int i = 1; i <= 5; i++)
            tbl[i] = mk(0, 8'h00, 8'h00, 32'h00, 1, 0, 8'h00, 0, 0, 32'h0, 0);
        tbl[6]  = mk(0, 8'h04, 8'h00, 32'hA0, 1, 1, 8'h00, 0, 0, 32'h0, 0);
        tbl[7]  = mk(0, 8'h04, 8'h00, 32'hA0, 1, 0, 8'h00, 1, 0, 32'h0, 0);
        tbl[8]  = mk(0, 8'h04, 8'h00, 32'hA0, 1, 0, 8'h04, 1, 0, 32'h0, 0);
        tbl[9]  = mk(0, 8'h0C, 8'h08, 32'hA1, 1, 0, 8'h04, 1, 1, 32'h020000A0, 0);
        tbl[10] = mk(0, 8'h04, 8'h04, 32'hA2, 1, 0, 8'h04, 1, 1, 32'h020000A1, 0);
        tbl[11] = mk(0, 8'h00, 8'h00, 32'h00, 1, 0, 8'h00, 0, 1, 32'h020000A2, 1);
        tbl[12] = mk(0, 8'h00, 8'h00, 32'h00, 1, 0, 8'h00, 0, 0, 32'h0, 0);

        prev_ov = 0; prev_ordy = 1; prev_od = '0; prev_ol = 0; prev_rst = 1; prev_last_acc = 0;
        rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].v;
            in_last   = tbl[i].l;
            out_ready = tbl[i].ordy;
            for (int p = 0; p < PORTS; p++)
                in_data[p*DWIDTH +: DWIDTH] = {8'(p), tbl[i].d[23:0]};
            @(negedge clk);
            chk($sformatf("v%0d_enable", i), arb_enable, tbl[i].en);
            chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
            if (tbl[i].ov) begin
                chk($sformatf("v%0d_out_data", i), out_data, tbl[i].od);
                chk($sformatf("v%0d_out_last", i), out_last, tbl[i].ol);
            end
            @(posedge clk);
            #1;
        end

        // Three simultaneous 2-beat packets: whole, in reset priority order 0,1,3.
        reset_all();
        push_beat(0, 24'h10, 0, 1); push_beat(0, 24'h11, 1, 1);
        push_beat(1, 24'h20, 0, 1); push_beat(1, 24'h21, 1, 1);
        push_beat(3, 24'h30, 0, 1); push_beat(3, 24'h31, 1, 1);
        drive_inputs(); next_ordy();
        run_until_idle("seqA", 100);

        // Mid-packet stall with out_ready 1,0,0,1.
        push_beat(4, 24'h40, 0, 1); push_beat(4, 24'h41, 0, 1);
        push_beat(4, 24'h42, 0, 1); push_beat(4, 24'h43, 1, 1);
        ordy_q = '{1, 1, 1, 1, 0, 0, 1};
        drive_inputs(); next_ordy();
        run_until_idle("seqB", 100);

        // Back-to-back single-beat packets on port 5: one every 3 cycles.
        acc_cyc_q.delete();
        push_beat(5, 24'h50, 1, 1); push_beat(5, 24'h51, 1, 1); push_beat(5, 24'h52, 1, 1);
        drive_inputs(); next_ordy();
        run_until_idle("seqC", 100);
        chk("seqC_accepts", acc_cyc_q.size(), 3);
        if (acc_cyc_q.size() == 3) begin
            chk("seqC_gap1", acc_cyc_q[1] - acc_cyc_q[0], 3);
            chk("seqC_gap2", acc_cyc_q[2] - acc_cyc_q[1], 3);
        end

        // Last beat held with out_ready low; the next packet must not overwrite it.
        push_beat(6, 24'h60, 1, 1); push_beat(7, 24'h70, 1, 1);
        for (int i = 0; i < 10; i++) ordy_q.push_back(1'b0);
        drive_inputs(); next_ordy();
        run_until_idle("seqD", 100);

        // Reset after beat 1 of 4: packet dropped, later request served cleanly.
        push_beat(1, 24'h90, 0, 1); push_beat(1, 24'h91, 0, 0);
        push_beat(1, 24'h92, 0, 0); push_beat(1, 24'h93, 1, 0);
        drive_inputs(); next_ordy();
        base = n_acc;
        for (int i = 0; i < 20 && n_acc == base; i++) step();
        got = (n_acc == base + 1);
        chk("seqE_first_accept", got, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("seqE_rst_busy", busy, 1'b0);
        chk("seqE_rst_out_valid", out_valid, 1'b0);
        chk("seqE_rst_in_ready", in_ready, '0);
        src_head[1] = src_tail[1];
        push_beat(3, 24'h3F, 1, 1);
        drive_inputs();
        run_until_idle("seqE", 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
